// File: rtl/noc_rr_collector_if.sv
// Producer-side and output-side signals of the many-to-one collector.
// master: the producers/consumer environment; slave: the collector itself.
interface noc_rr_collector_if #(
  parameter int CPU_NB = 4
);
  localparam int SW = (CPU_NB > 1) ? $clog2(CPU_NB) : 1;

  logic          data_vld [CPU_NB];
  logic [63:0]   data     [CPU_NB];
  logic          data_rdy [CPU_NB];

  logic          out_vld;
  logic [SW-1:0] out_src;
  logic [63:0]   out_data;
  logic [31:0]   out_cnt;

  modport master (
    output data_vld, data,
    input  data_rdy, out_vld, out_src, out_data, out_cnt
  );

  modport slave (
    input  data_vld, data,
    output data_rdy, out_vld, out_src, out_data, out_cnt
  );
endinterface

// File: rtl/noc_rr_collector.sv
// Many-to-one collector: one-entry ingress buffer per source, round-robin
// drain onto a single registered output stream tagged with the source index.
module noc_rr_collector #(
  parameter int CPU_NB = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  noc_rr_collector_if.slave  bus
);
  localparam int          SW = (CPU_NB > 1) ? $clog2(CPU_NB) : 1;
  localparam int unsigned N  = CPU_NB;

  logic          buf_full_q [CPU_NB];
  logic          buf_full_d [CPU_NB];
  logic [63:0]   buf_data_q [CPU_NB];
  logic [63:0]   buf_data_d [CPU_NB];
  logic [SW-1:0] ptr_q, ptr_d;
  logic          out_vld_q, out_vld_d;
  logic [SW-1:0] out_src_q, out_src_d;
  logic [63:0]   out_data_q, out_data_d;
  logic [31:0]   out_cnt_q, out_cnt_d;

  logic          grant [CPU_NB];
  logic          gnt_any;
  logic [SW-1:0] gnt_idx;
  logic          rdy [CPU_NB];

  // Round-robin search starting just after the last granted index.
  always_comb begin
    logic [SW-1:0] cand;
    for (int unsigned i = 0; i < N; i++) grant[i] = 1'b0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = SW'((32'(ptr_q) + off) % N);
      if (!gnt_any && buf_full_q[cand]) begin
        grant[cand] = 1'b1;
        gnt_any     = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

  // Ready depends only on buffer state and the grant, never on data_vld.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      rdy[i] = rst_n & (~buf_full_q[i] | grant[i]);
    end
  end

  // Next-state for buffers (drain, then refill wins) and the output stage.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      buf_full_d[i] = buf_full_q[i];
      buf_data_d[i] = buf_data_q[i];
      if (grant[i]) buf_full_d[i] = 1'b0;
      if (bus.data_vld[i] && rdy[i]) begin
        buf_full_d[i] = 1'b1;
        buf_data_d[i] = bus.data[i];
      end
    end
    ptr_d      = ptr_q;
    out_vld_d  = gnt_any;
    out_src_d  = out_src_q;
    out_data_d = out_data_q;
    out_cnt_d  = out_cnt_q;
    if (gnt_any) begin
      ptr_d      = gnt_idx;
      out_src_d  = gnt_idx;
      out_data_d = buf_data_q[gnt_idx];
      out_cnt_d  = out_cnt_q + 32'd1;
    end
  end

  // State registers; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        buf_full_q[i] <= 1'b0;
        buf_data_q[i] <= '0;
      end
      ptr_q      <= SW'(CPU_NB - 1);
      out_vld_q  <= 1'b0;
      out_src_q  <= '0;
      out_data_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        buf_full_q[i] <= buf_full_d[i];
        buf_data_q[i] <= buf_data_d[i];
      end
      ptr_q      <= ptr_d;
      out_vld_q  <= out_vld_d;
      out_src_q  <= out_src_d;
      out_data_q <= out_data_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  assign bus.data_rdy = rdy;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_src  = out_src_q;
  assign bus.out_data = out_data_q;
  assign bus.out_cnt  = out_cnt_q;
endmodule

// File: tb/tb_noc_rr_collector.sv
// Randomized bench for noc_rr_collector with a cycle-level reference model
// and a per-source scoreboard of accepted words.
module tb_noc_rr_collector;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  noc_rr_collector_if #(.CPU_NB(N)) bus ();
  noc_rr_collector #(.CPU_NB(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit            m_full [N];
  logic [63:0]   m_data [N];
  int            m_ptr;
  bit            m_ovld;
  logic [SW-1:0] m_osrc;
  logic [63:0]   m_odata;
  logic [31:0]   m_cnt;
  int            m_g;
  bit            exp_rdy [N];
  logic [63:0]   sent_q [N][$];
  int            sent_cnt [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_data[i] = '0; sent_q[i].delete(); sent_cnt[i] = 0;
    end
    m_ptr = N - 1; m_ovld = 0; m_osrc = '0; m_odata = '0; m_cnt = '0;
  endtask

  task automatic model_comb();
    m_g = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (m_g < 0 && m_full[j]) m_g = j;
    end
    for (int i = 0; i < N; i++) exp_rdy[i] = rst_n && (!m_full[i] || m_g == i);
  endtask

  task automatic drive_idle();
    for (int i = 0; i < N; i++) begin
      bus.data_vld[i] = 1'b0; bus.data[i] = '0;
    end
  endtask

  // Advance one clock: update the model at the edge, sample 1 time unit later.
  task automatic tick();
    bit          acc [N];
    logic [63:0] din [N];
    model_comb();
    for (int i = 0; i < N; i++) begin
      acc[i] = bus.data_vld[i] && exp_rdy[i];
      din[i] = bus.data[i];
    end
    @(posedge clk);
    if (rst_n) begin
      if (m_g >= 0) begin
        m_ovld = 1; m_osrc = SW'(m_g); m_odata = m_data[m_g];
        m_ptr = m_g; m_cnt = m_cnt + 1; m_full[m_g] = 0;
      end else m_ovld = 0;
      for (int i = 0; i < N; i++) if (acc[i]) begin
        m_full[i] = 1; m_data[i] = din[i];
        sent_q[i].push_back(din[i]); sent_cnt[i]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.data_vld[i] = 1'b1; bus.data[i] = {$urandom, $urandom};
    end
    tick(); tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bus.data_rdy[i] !== 1'b0) begin
        errors++; $display("FAIL reset_rdy[%0d] got=%b exp=0", i, bus.data_rdy[i]);
      end
    end
    checks++;
    if (bus.out_vld !== 1'b0 || bus.out_cnt !== 32'd0 || bus.out_data !== 64'd0 || bus.out_src !== 2'd0) begin
      errors++;
      $display("FAIL reset_out got vld=%b cnt=%0d data=%h src=%0d exp 0/0/0/0",
               bus.out_vld, bus.out_cnt, bus.out_data, bus.out_src);
    end
    drive_idle();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bus.data_rdy[i] !== 1'b1) begin
        errors++; $display("FAIL release_rdy[%0d] got=%b exp=1", i, bus.data_rdy[i]);
      end
    end
  endtask

  task automatic test_single_source();
    logic [63:0] obs [$];
    int first_out = -1;
    for (int c = 0; c < 6; c++) begin
      drive_idle();
      if (c < 3) begin bus.data_vld[2] = 1'b1; bus.data[2] = 64'(c + 1); end
      model_comb();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (bus.data_rdy[i] !== exp_rdy[i]) begin
          errors++; $display("FAIL single_rdy[%0d] c=%0d got=%b exp=%b", i, c, bus.data_rdy[i], exp_rdy[i]);
        end
      end
      tick();
      checks++;
      if (bus.out_vld !== m_ovld || bus.out_src !== m_osrc || bus.out_data !== m_odata || bus.out_cnt !== m_cnt) begin
        errors++;
        $display("FAIL single_out c=%0d got vld=%b src=%0d data=%h cnt=%0d exp vld=%b src=%0d data=%h cnt=%0d",
                 c, bus.out_vld, bus.out_src, bus.out_data, bus.out_cnt, m_ovld, m_osrc, m_odata, m_cnt);
      end
      if (bus.out_vld === 1'b1) begin
        if (first_out < 0) first_out = c;
        obs.push_back(bus.out_data);
        checks++;
        if (bus.out_src !== 2'd2) begin
          errors++; $display("FAIL single_src got=%0d exp=2", bus.out_src);
        end
      end
    end
    checks++;
    if (obs.size() != 3 || obs[0] !== 64'd1 || obs[1] !== 64'd2 || obs[2] !== 64'd3 || first_out != 1) begin
      errors++;
      $display("FAIL single_seq got n=%0d first_cycle=%0d exp n=3 data=1,2,3 first_cycle=1", obs.size(), first_out);
    end
    checks++;
    if (bus.out_cnt !== 32'd3) begin
      errors++; $display("FAIL single_cnt got=%0d exp=3", bus.out_cnt);
    end
    for (int i = 0; i < N; i++) sent_q[i].delete();
  endtask

  // mode 0: all sources always valid; mode 1: sources 1 and 3 only; mode 2: random
  task automatic run_traffic(input int mode, input int active, input string tag);
    int last_src = -1;
    int low_seen = 0;
    for (int c = 0; c < active + N + 2; c++) begin
      drive_idle();
      if (c < active) begin
        for (int i = 0; i < N; i++) begin
          case (mode)
            0: begin bus.data_vld[i] = 1'b1; bus.data[i] = 64'(32'h100 * i + sent_cnt[i]); end
            1: if (i == 1 || i == 3) begin bus.data_vld[i] = 1'b1; bus.data[i] = 64'(32'hB000 + 32'h100 * i + sent_cnt[i]); end
            default: begin bus.data_vld[i] = 1'($urandom_range(0, 1)); bus.data[i] = {$urandom, $urandom}; end
          endcase
        end
      end
      model_comb();
      if (bus.data_vld[1] === 1'b1 && bus.data_rdy[1] === 1'b0) low_seen++;
      for (int i = 0; i < N; i++) begin
        checks++;
        if (bus.data_rdy[i] !== exp_rdy[i]) begin
          errors++; $display("FAIL %s_rdy[%0d] c=%0d got=%b exp=%b", tag, i, c, bus.data_rdy[i], exp_rdy[i]);
        end
      end
      tick();
      checks++;
      if (bus.out_vld !== m_ovld || bus.out_src !== m_osrc || bus.out_data !== m_odata || bus.out_cnt !== m_cnt) begin
        errors++;
        $display("FAIL %s_out c=%0d got vld=%b src=%0d data=%h cnt=%0d exp vld=%b src=%0d data=%h cnt=%0d",
                 tag, c, bus.out_vld, bus.out_src, bus.out_data, bus.out_cnt, m_ovld, m_osrc, m_odata, m_cnt);
      end
      if (bus.out_vld === 1'b1) begin
        checks++;
        if (sent_q[bus.out_src].size() == 0 || sent_q[bus.out_src][0] !== bus.out_data) begin
          errors++;
          $display("FAIL %s_order src=%0d got=%h exp=%h", tag, bus.out_src, bus.out_data,
                   (sent_q[bus.out_src].size() != 0) ? sent_q[bus.out_src][0] : 64'hx);
        end
        if (sent_q[bus.out_src].size() != 0) void'(sent_q[bus.out_src].pop_front());
        if (mode == 0 && last_src >= 0) begin
          checks++;
          if (int'(bus.out_src) != (last_src + 1) % N) begin
            errors++; $display("FAIL %s_rotation got=%0d exp=%0d", tag, bus.out_src, (last_src + 1) % N);
          end
        end
        last_src = int'(bus.out_src);
      end
      if (mode == 0 && c >= 1 && c < active) begin
        checks++;
        if (bus.out_vld !== 1'b1) begin
          errors++; $display("FAIL %s_throughput c=%0d got vld=%b exp=1", tag, c, bus.out_vld);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sent_q[i].size() != 0) begin
        errors++; $display("FAIL %s_undelivered[%0d] got=%0d words left exp=0", tag, i, sent_q[i].size());
      end
    end
    if (mode == 1) begin
      checks++;
      if (low_seen == 0) begin
        errors++; $display("FAIL %s_rdy1_low got=%0d stalled cycles exp>0", tag, low_seen);
      end
    end
  endtask

  task automatic test_round_robin();  run_traffic(0, 20, "rr");    endtask
  task automatic test_backpressure(); run_traffic(1, 12, "bp");    endtask
  task automatic test_random();       run_traffic(2, 300, "rand"); endtask

  task automatic test_mid_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.data_vld[i] = 1'b1; bus.data[i] = {$urandom, $urandom};
      end
      tick();
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_vld !== 1'b0 || bus.out_cnt !== 32'd0 || bus.out_data !== 64'd0 || bus.out_src !== 2'd0) begin
      errors++;
      $display("FAIL midrst_out got vld=%b cnt=%0d data=%h src=%0d exp 0/0/0/0",
               bus.out_vld, bus.out_cnt, bus.out_data, bus.out_src);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bus.data_rdy[i] !== 1'b0) begin
        errors++; $display("FAIL midrst_rdy[%0d] got=%b exp=0", i, bus.data_rdy[i]);
      end
    end
    model_reset();
    drive_idle();
    bus.data_vld[0] = 1'b1; bus.data[0] = 64'hA0;
    bus.data_vld[3] = 1'b1; bus.data[3] = 64'hA3;
    #2 rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bus.data_rdy[i] !== 1'b1) begin
        errors++; $display("FAIL midrst_release_rdy[%0d] got=%b exp=1", i, bus.data_rdy[i]);
      end
    end
    tick();
    checks++;
    if (bus.out_vld !== 1'b0) begin
      errors++; $display("FAIL midrst_stale got vld=%b data=%h exp vld=0", bus.out_vld, bus.out_data);
    end
    drive_idle();
    tick();
    checks++;
    if (bus.out_vld !== 1'b1 || bus.out_src !== 2'd0 || bus.out_data !== 64'hA0 || bus.out_cnt !== 32'd1) begin
      errors++;
      $display("FAIL midrst_first got vld=%b src=%0d data=%h cnt=%0d exp vld=1 src=0 data=a0 cnt=1",
               bus.out_vld, bus.out_src, bus.out_data, bus.out_cnt);
    end
    tick();
    checks++;
    if (bus.out_vld !== 1'b1 || bus.out_src !== 2'd3 || bus.out_data !== 64'hA3) begin
      errors++;
      $display("FAIL midrst_second got vld=%b src=%0d data=%h exp vld=1 src=3 data=a3",
               bus.out_vld, bus.out_src, bus.out_data);
    end
    tick();
    for (int i = 0; i < N; i++) sent_q[i].delete();
  endtask

  task automatic test_counter_wrap();
    drive_idle();
    force dut.out_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.out_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (bus.out_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_preset got=%h exp=ffffffff", bus.out_cnt);
    end
    for (int c = 0; c < 4; c++) begin
      drive_idle();
      if (c < 2) begin bus.data_vld[0] = 1'b1; bus.data[0] = 64'(c + 32'h55); end
      tick();
      checks++;
      if (bus.out_cnt !== m_cnt || bus.out_vld !== m_ovld) begin
        errors++;
        $display("FAIL wrap_step c=%0d got cnt=%h vld=%b exp cnt=%h vld=%b", c, bus.out_cnt, bus.out_vld, m_cnt, m_ovld);
      end
    end
    checks++;
    if (bus.out_cnt !== 32'h0000_0001) begin
      errors++; $display("FAIL wrap_final got=%h exp=00000001", bus.out_cnt);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end
endmodule
